// File: rtl/key_input_avmm_if.sv
// Avalon-MM slave bus bundle for the debounced key input block.
// The master side (interconnect) drives address, strobes and write data;
// the slave side returns read data, its valid pulse and waitrequest.
interface key_input_avmm_if;
    logic [1:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;
    logic        avs_readdatavalid;
    logic        avs_waitrequest;

    modport master (
        output avs_address,
        output avs_read,
        output avs_write,
        output avs_writedata,
        input  avs_readdata,
        input  avs_readdatavalid,
        input  avs_waitrequest
    );

    modport slave (
        input  avs_address,
        input  avs_read,
        input  avs_write,
        input  avs_writedata,
        output avs_readdata,
        output avs_readdatavalid,
        output avs_waitrequest
    );
endinterface

// File: rtl/key_input_avmm.sv
// Debounced board-input responder on the Avalon-MM interconnect.
// Each raw pad bit is synchronised through two flops, debounced with a
// per-bit stability counter, and edge-detected. Selected edges are latched
// in EDGE_CAP (write-1-to-clear) and masked into a registered level IRQ.
// Register map (word address): 0 DATA (RO), 1 IRQ_MASK, 2 EDGE_CAP (W1C), 3 EDGE_SEL.
module key_input_avmm #(
    parameter int unsigned      WIDTH           = 8,
    parameter int unsigned      DEBOUNCE_CYCLES = 250000,
    parameter logic [WIDTH-1:0] RESET_LEVEL     = {WIDTH{1'b1}}
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [WIDTH-1:0]   pad_in,
    key_input_avmm_if.slave    avs,
    output logic               irq
);

    localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        REG_DATA     = 2'd0,
        REG_IRQ_MASK = 2'd1,
        REG_EDGE_CAP = 2'd2,
        REG_EDGE_SEL = 2'd3
    } reg_addr_e;

    reg_addr_e        reg_addr;
    logic [WIDTH-1:0] wr_bits;

    logic [WIDTH-1:0] sync1_q, sync1_d;
    logic [WIDTH-1:0] sync2_q, sync2_d;
    logic [WIDTH-1:0] deb_q, deb_d;
    logic [WIDTH-1:0][CNT_W-1:0] cnt_q, cnt_d;

    logic [WIDTH-1:0] rise, fall, hit, w1c;

    logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
    logic [WIDTH-1:0] edge_cap_q, edge_cap_d;
    logic [WIDTH-1:0] edge_sel_q, edge_sel_d;

    logic [31:0] rdata_q, rdata_d;
    logic        rvalid_q, rvalid_d;
    logic        irq_q, irq_d;

    assign reg_addr = reg_addr_e'(avs.avs_address);
    assign wr_bits  = avs.avs_writedata[WIDTH-1:0];

    // Two-stage synchroniser; both stages reset to the idle level so reset release is edge-free.
    always_comb begin
        sync1_d = pad_in;
        sync2_d = sync1_q;
    end

    // Per-bit debounce: count consecutive cycles the synced level disagrees, accept it on the last one.
    always_comb begin
        deb_d = deb_q;
        cnt_d = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    deb_d[i] = sync2_q[i];
                    cnt_d[i] = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // Edge pulses fire in the cycle the debounced level is about to change; EDGE_SEL picks rise or fall.
    always_comb begin
        rise = deb_d & ~deb_q;
        fall = ~deb_d & deb_q;
        hit  = (edge_sel_q & rise) | (~edge_sel_q & fall);
    end

    // Register writes; in EDGE_CAP a fresh hit overrides a same-cycle W1C on that bit.
    always_comb begin
        irq_mask_d = irq_mask_q;
        edge_sel_d = edge_sel_q;
        w1c        = '0;
        if (avs.avs_write) begin
            case (reg_addr)
                REG_IRQ_MASK: irq_mask_d = wr_bits;
                REG_EDGE_CAP: w1c        = wr_bits;
                REG_EDGE_SEL: edge_sel_d = wr_bits;
                default:      ;
            endcase
        end
        edge_cap_d = (edge_cap_q & ~w1c) | hit;
    end

    // Read mux samples pre-write register values; readdata holds between reads.
    always_comb begin
        rdata_d  = rdata_q;
        rvalid_d = avs.avs_read;
        if (avs.avs_read) begin
            case (reg_addr)
                REG_DATA:     rdata_d = 32'(deb_q);
                REG_IRQ_MASK: rdata_d = 32'(irq_mask_q);
                REG_EDGE_CAP: rdata_d = 32'(edge_cap_q);
                REG_EDGE_SEL: rdata_d = 32'(edge_sel_q);
                default:      rdata_d = '0;
            endcase
        end
    end

    // Level interrupt from captured-and-enabled edges, registered one cycle behind the registers.
    always_comb begin
        irq_d = |(edge_cap_q & irq_mask_q);
    end

    // Input path state: synchroniser, debounced level and stability counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= RESET_LEVEL;
            sync2_q <= RESET_LEVEL;
            deb_q   <= RESET_LEVEL;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            deb_q   <= deb_d;
            cnt_q   <= cnt_d;
        end
    end

    // Software-visible registers and bus/irq outputs; reset drops any read in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_mask_q <= '0;
            edge_cap_q <= '0;
            edge_sel_q <= '0;
            rdata_q    <= '0;
            rvalid_q   <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            irq_mask_q <= irq_mask_d;
            edge_cap_q <= edge_cap_d;
            edge_sel_q <= edge_sel_d;
            rdata_q    <= rdata_d;
            rvalid_q   <= rvalid_d;
            irq_q      <= irq_d;
        end
    end

    assign avs.avs_readdata      = rdata_q;
    assign avs.avs_readdatavalid = rvalid_q;
    assign avs.avs_waitrequest   = 1'b0;
    assign irq                   = irq_q;

endmodule

// File: tb/tb_key_input_avmm.sv
// Testbench for key_input_avmm: directed scenarios followed by random pad/bus
// traffic. A reference model predicts read data and irq; reads are pushed to a
// scoreboard queue and a separate monitor compares them when readdatavalid shows.
module tb_key_input_avmm;

    localparam int         WIDTH   = 8;
    localparam int         DEB     = 4;
    localparam logic [7:0] RST_LVL = 8'hFF;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] pad_in = RST_LVL;
    logic       irq;

    key_input_avmm_if bus ();

    key_input_avmm #(
        .WIDTH(WIDTH),
        .DEBOUNCE_CYCLES(DEB),
        .RESET_LEVEL(RST_LVL)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .pad_in(pad_in),
        .avs(bus),
        .irq(irq)
    );

    always #5 clk = ~clk;

    // Scoreboard: model pushes expected read data, monitor consumes by index.
    logic [31:0] exp_q[$];
    int          exp_base = 0;
    int          rd_idx = 0;
    logic [31:0] last_rdata = '0;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state: register contents and the recent pad samples.
    logic [7:0] m_deb, m_mask, m_cap, m_sel;
    logic       m_irq;
    logic [7:0] pad_hist[$];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    endtask

    function automatic logic [31:0] model_read(input logic [1:0] a);
        case (a)
            2'd0:    return 32'(m_deb);
            2'd1:    return 32'(m_mask);
            2'd2:    return 32'(m_cap);
            default: return 32'(m_sel);
        endcase
    endfunction

    task automatic model_reset();
        m_deb  = RST_LVL;
        m_mask = '0;
        m_cap  = '0;
        m_sel  = '0;
        m_irq  = 1'b0;
        pad_hist.delete();
        for (int k = 0; k < DEB + 1; k++) pad_hist.push_back(RST_LVL);
    endtask

    // A bit's accepted level flips once the pad has shown the opposite value for
    // DEB consecutive samples, counted from two cycles back (synchroniser delay).
    task automatic model_step();
        logic [7:0] new_deb, rise, fall, hit, clr;
        bit         all_diff;
        if (bus.avs_read) exp_q.push_back(model_read(bus.avs_address));
        m_irq   = |(m_cap & m_mask);
        new_deb = m_deb;
        for (int i = 0; i < WIDTH; i++) begin
            all_diff = 1'b1;
            for (int j = 0; j < DEB; j++)
                if (pad_hist[j][i] == m_deb[i]) all_diff = 1'b0;
            if (all_diff) new_deb[i] = ~m_deb[i];
        end
        rise = new_deb & ~m_deb;
        fall = ~new_deb & m_deb;
        hit  = (m_sel & rise) | (~m_sel & fall);
        clr  = (bus.avs_write && bus.avs_address == 2'd2) ? bus.avs_writedata[7:0] : 8'h00;
        m_cap = (m_cap & ~clr) | hit;
        if (bus.avs_write && bus.avs_address == 2'd1) m_mask = bus.avs_writedata[7:0];
        if (bus.avs_write && bus.avs_address == 2'd3) m_sel  = bus.avs_writedata[7:0];
        m_deb = new_deb;
        pad_hist.push_back(pad_in);
        void'(pad_hist.pop_front());
    endtask

    // Reference model process, reset asynchronously like the design.
    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                model_reset();
                exp_base = exp_q.size();
            end else begin
                model_step();
            end
        end
    end

    // Monitor: irq every cycle, and each expected read must show valid the cycle after it was issued.
    initial begin
        forever begin
            @(negedge clk);
            if (rd_idx < exp_base) rd_idx = exp_base;
            if (!reset_n) begin
                checkOutput("valid_in_reset", 32'(bus.avs_readdatavalid), 32'd0);
                checkOutput("irq_in_reset", 32'(irq), 32'd0);
            end else begin
                checkOutput("irq", 32'(irq), 32'(m_irq));
                if (rd_idx < exp_q.size()) begin
                    checkOutput("readdatavalid", 32'(bus.avs_readdatavalid), 32'd1);
                    if (bus.avs_readdatavalid) begin
                        checkOutput("readdata", bus.avs_readdata, exp_q[rd_idx]);
                        last_rdata = bus.avs_readdata;
                    end
                    rd_idx++;
                end else if (bus.avs_readdatavalid) begin
                    checkOutput("spurious_valid", 32'(bus.avs_readdatavalid), 32'd0);
                end
            end
        end
    end

    // Safety net so the bench always terminates.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input logic [7:0] pad, input logic rd, input logic wr,
                                 input logic [1:0] addr, input logic [31:0] wd);
        pad_in            = pad;
        bus.avs_read      = rd;
        bus.avs_write     = wr;
        bus.avs_address   = addr;
        bus.avs_writedata = wd;
        @(posedge clk);
        #1;
        bus.avs_read  = 1'b0;
        bus.avs_write = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(pad_in, 1'b0, 1'b0, 2'd0, 32'd0);
    endtask

    task automatic doWrite(input logic [1:0] addr, input logic [31:0] wd);
        applyStimulus(pad_in, 1'b0, 1'b1, addr, wd);
    endtask

    task automatic doRead(input logic [1:0] addr, output logic [31:0] data);
        applyStimulus(pad_in, 1'b1, 1'b0, addr, 32'd0);
        @(negedge clk);
        #1;
        data = last_rdata;
        @(posedge clk);
        #1;
    endtask

    logic [31:0] d;
    logic [7:0]  pad_cur;
    int          op;

    initial begin
        bus.avs_read      = 1'b0;
        bus.avs_write     = 1'b0;
        bus.avs_address   = 2'd0;
        bus.avs_writedata = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;

        $display("[TB] reset state");
        doRead(2'd0, d);
        checkOutput("t1_data", d, 32'h0000_00FF);
        doRead(2'd2, d);
        checkOutput("t1_edge_cap", d, 32'h0);
        checkOutput("t1_irq", 32'(irq), 32'd0);
        checkOutput("t1_waitrequest", 32'(bus.avs_waitrequest), 32'd0);

        $display("[TB] key press on bit 0");
        doWrite(2'd1, 32'h01);
        applyStimulus(8'hFE, 1'b0, 1'b0, 2'd0, 32'd0);
        idle(9);
        checkOutput("t2_irq", 32'(irq), 32'd1);
        doRead(2'd0, d);
        checkOutput("t2_data", d, 32'h0000_00FE);
        doRead(2'd2, d);
        checkOutput("t2_edge_cap", d, 32'h01);
        doWrite(2'd2, 32'h01);
        idle(2);
        checkOutput("t2_irq_cleared", 32'(irq), 32'd0);
        applyStimulus(8'hFF, 1'b0, 1'b0, 2'd0, 32'd0);
        idle(10);

        $display("[TB] bouncing bit 1");
        for (int k = 0; k < 20; k++) begin
            applyStimulus(pad_in ^ 8'h02, 1'b0, 1'b0, 2'd0, 32'd0);
            idle(1);
        end
        idle(6);
        doRead(2'd0, d);
        checkOutput("t3_data", d, 32'h0000_00FF);
        doRead(2'd2, d);
        checkOutput("t3_edge_cap", d, 32'h0);
        checkOutput("t3_irq", 32'(irq), 32'd0);

        $display("[TB] rising edge select and W1C");
        doWrite(2'd3, 32'h02);
        doWrite(2'd1, 32'h02);
        applyStimulus(8'hFD, 1'b0, 1'b0, 2'd0, 32'd0);
        idle(9);
        applyStimulus(8'hFF, 1'b0, 1'b0, 2'd0, 32'd0);
        idle(9);
        doRead(2'd2, d);
        checkOutput("t4_edge_cap", d, 32'h02);
        checkOutput("t4_irq_set", 32'(irq), 32'd1);
        doWrite(2'd2, 32'h02);
        checkOutput("t4_irq_hold", 32'(irq), 32'd1);
        idle(1);
        checkOutput("t4_irq_drop", 32'(irq), 32'd0);
        doRead(2'd2, d);
        checkOutput("t4_edge_cap_clr", d, 32'h0);

        $display("[TB] set beats W1C");
        doWrite(2'd3, 32'h00);
        doWrite(2'd1, 32'h01);
        applyStimulus(8'hFE, 1'b0, 1'b0, 2'd0, 32'd0);
        idle(4);
        applyStimulus(8'hFE, 1'b0, 1'b1, 2'd2, 32'h01);
        idle(1);
        doRead(2'd2, d);
        checkOutput("t5_set_wins", d & 32'h1, 32'h1);
        doWrite(2'd2, 32'hFF);
        applyStimulus(8'hFF, 1'b0, 1'b0, 2'd0, 32'd0);
        idle(8);

        $display("[TB] back-to-back reads and reset mid-debounce");
        for (int a = 0; a < 4; a++) applyStimulus(pad_in, 1'b1, 1'b0, 2'(a), 32'd0);
        idle(2);
        applyStimulus(8'hFE, 1'b0, 1'b0, 2'd0, 32'd0);
        idle(1);
        applyStimulus(8'hFE, 1'b1, 1'b0, 2'd0, 32'd0);
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        doRead(2'd0, d);
        checkOutput("t6_data_after_reset", d, 32'h0000_00FF);
        applyStimulus(8'hFF, 1'b0, 1'b0, 2'd0, 32'd0);
        idle(8);
        doWrite(2'd2, 32'hFF);

        $display("[TB] random traffic");
        pad_cur = 8'hFF;
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 5) == 0) pad_cur = pad_cur ^ 8'($urandom_range(1, 255));
            op = int'($urandom_range(0, 3));
            applyStimulus(pad_cur, (op == 1 || op == 3), (op >= 2),
                          2'($urandom_range(0, 3)), $urandom);
        end
        idle(4);
        checkOutput("scoreboard_drain", 32'(rd_idx), 32'(exp_q.size()));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
